// File: rtl/wb_counter_bank_if.sv
// Wishbone classic slave signal bundle for wb_counter_bank.
interface wb_counter_bank_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/wb_counter_bank.sv
// Bank of NCH up/down counters with compare match flags, W1C status and a
// level interrupt, behind a single-wait-state Wishbone classic slave.
module wb_counter_bank #(
   parameter int NCH   = 4,
   parameter int WIDTH = 16
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_ni,
   wb_counter_bank_if.slave     wbs,
   output logic [NCH*WIDTH-1:0] count_o,
   output logic                 irq_o
);
   localparam logic [1:0] REG_CTRL  = 2'd0;
   localparam logic [1:0] REG_COUNT = 2'd1;
   localparam logic [1:0] REG_CMP   = 2'd2;

   logic                      r_ack;
   logic [31:0]               r_dat;
   logic                      r_irq;
   logic                      w_req;
   logic                      w_wr;
   logic                      w_stat_sel;
   logic [2:0]                w_ch;
   logic [1:0]                w_reg;
   logic [31:0]               w_rdata;
   logic [NCH-1:0][3:0]       w_ctrl;
   logic [NCH-1:0][WIDTH-1:0] w_count;
   logic [NCH-1:0][WIDTH-1:0] w_cmp;
   logic [NCH-1:0]            w_flag;
   logic [NCH-1:0]            w_ien;
   logic                      w_unused;

   // Masking with r_ack makes the ack cycle itself never a new request.
   assign w_req      = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~r_ack;
   assign w_wr       = w_req & wbs.wbs_we_i;
   assign w_ch       = wbs.wbs_adr_i[6:4];
   assign w_reg      = wbs.wbs_adr_i[3:2];
   assign w_stat_sel = wbs.wbs_adr_i[8] && (w_reg == 2'd0);
   assign w_unused   = ^{wbs.wbs_adr_i[31:9], wbs.wbs_adr_i[7], wbs.wbs_adr_i[1:0]};

   function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] sel);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) res[b*8 +: 8] = sel[b] ? wd[b*8 +: 8] : old[b*8 +: 8];
      return res;
   endfunction

   for (genvar n = 0; n < NCH; n++) begin : g_ch
      logic [3:0]       r_ctrl;
      logic [WIDTH-1:0] r_count;
      logic [WIDTH-1:0] r_cmp;
      logic             r_flag;
      logic             w_sel;
      logic             w_hit;
      logic             w_clr;
      logic [31:0]      w_cnt_m;
      logic [31:0]      w_cmp_m;

      assign w_sel   = ~wbs.wbs_adr_i[8] && (w_ch == 3'(n));
      assign w_hit   = r_ctrl[2] ? (r_count == '0) : (r_count == r_cmp);
      assign w_clr   = w_wr && w_stat_sel && wbs.wbs_sel_i[0] && wbs.wbs_dat_i[n];
      assign w_cnt_m = f_merge(32'(r_count), wbs.wbs_dat_i, wbs.wbs_sel_i);
      assign w_cmp_m = f_merge(32'(r_cmp), wbs.wbs_dat_i, wbs.wbs_sel_i);

      // NOTE: non-blocking assignments let a later assignment in the same block
      // override an earlier one at the edge; the ordering below encodes the
      // priorities (match set beats W1C clear, bus write beats count update).
      always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
         if (!wb_rst_ni) begin
            r_ctrl  <= '0;
            r_count <= '0;
            r_cmp   <= '0;
            r_flag  <= 1'b0;
         end else begin
            if (w_clr) r_flag <= 1'b0;
            if (r_ctrl[0]) begin
               if (w_hit) begin
                  r_flag <= 1'b1;
                  if (r_ctrl[1])      r_ctrl[0] <= 1'b0;
                  else if (r_ctrl[2]) r_count   <= r_cmp;
                  else                r_count   <= '0;
               end else if (r_ctrl[2]) begin
                  r_count <= r_count - WIDTH'(1);
               end else begin
                  r_count <= r_count + WIDTH'(1);
               end
            end
            if (w_wr && w_sel) begin
               case (w_reg)
                  REG_CTRL:  if (wbs.wbs_sel_i[0]) r_ctrl <= wbs.wbs_dat_i[3:0];
                  REG_COUNT: r_count <= WIDTH'(w_cnt_m);
                  REG_CMP:   r_cmp   <= WIDTH'(w_cmp_m);
                  default:   ;
               endcase
            end
         end
      end

      assign w_ctrl[n]  = r_ctrl;
      assign w_count[n] = r_count;
      assign w_cmp[n]   = r_cmp;
      assign w_flag[n]  = r_flag;
      assign w_ien[n]   = r_ctrl[3];
   end

   // NOTE: the default assignment up front keeps this combinational mux from
   // inferring latches on the unmatched address paths.
   always_comb begin
      w_rdata = '0;
      if (w_stat_sel) begin
         w_rdata = 32'(w_flag);
      end else if (!wbs.wbs_adr_i[8]) begin
         for (int n = 0; n < NCH; n++) begin
            if (w_ch == 3'(n)) begin
               case (w_reg)
                  REG_CTRL:  w_rdata = {28'd0, w_ctrl[n]};
                  REG_COUNT: w_rdata = 32'(w_count[n]);
                  REG_CMP:   w_rdata = 32'(w_cmp[n]);
                  default:   w_rdata = '0;
               endcase
            end
         end
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_ack <= 1'b0;
         r_dat <= '0;
         r_irq <= 1'b0;
      end else begin
         r_ack <= w_req;
         r_dat <= (w_req && !wbs.wbs_we_i) ? w_rdata : '0;
         r_irq <= |(w_flag & w_ien);
      end
   end

   assign wbs.wbs_ack_o = r_ack;
   assign wbs.wbs_dat_o = r_dat;
   assign count_o       = w_count;
   assign irq_o         = r_irq;
endmodule

// File: tb/tb_wb_counter_bank.sv
// Directed bench for wb_counter_bank: register table plus counting, collision
// and reset sequences.
module tb_wb_counter_bank;
   localparam int NCH   = 4;
   localparam int WIDTH = 16;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NCH*WIDTH-1:0] count_o;
   logic                 irq_o;
   int                   n_checks = 0;
   int                   n_errors = 0;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];

   wb_counter_bank_if bus();

   wb_counter_bank #(.NCH(NCH), .WIDTH(WIDTH)) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .wbs       (bus),
      .count_o   (count_o),
      .irq_o     (irq_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ch_cnt(input int n);
      return 32'(count_o[n*WIDTH +: WIDTH]);
   endfunction

   task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] rd);
      int waited;
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = dat;
      bus.wbs_sel_i = sel;
      waited = 0;
      do begin
         @(posedge clk);
         #1;
         waited++;
      end while (!bus.wbs_ack_o && waited < 8);
      check("ack_latency", 32'(waited), 32'd1);
      rd = bus.wbs_dat_o;
      @(negedge clk);
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      @(posedge clk);
      #1;
      check("ack_width", 32'(bus.wbs_ack_o), 32'd0);
      check("dat_idle", bus.wbs_dat_o, 32'd0);
   endtask

   task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      logic [31:0] dummy;
      wb_xfer(1'b1, adr, dat, sel, dummy);
   endtask

   task automatic wb_read_check(input string name, input logic [31:0] adr, input logic [31:0] exp);
      logic [31:0] rd;
      wb_xfer(1'b0, adr, 32'd0, 4'h0, rd);
      check(name, rd, exp);
   endtask

   initial begin
      logic [31:0] rd;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_sel_i = 4'h0;
      bus.wbs_dat_i = 32'd0;
      bus.wbs_adr_i = 32'd0;

      repeat (3) @(negedge clk);
      check("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
      check("rst_count_lo", count_o[31:0], 32'd0);
      check("rst_count_hi", count_o[63:32], 32'd0);
      check("rst_irq", 32'(irq_o), 32'd0);
      rst_n = 1'b1;

      vecs.push_back('{1'b0, 32'h000, 32'h0,        4'h0, 32'h0,      "rd_ctrl0"});
      vecs.push_back('{1'b0, 32'h004, 32'h0,        4'h0, 32'h0,      "rd_count0"});
      vecs.push_back('{1'b0, 32'h008, 32'h0,        4'h0, 32'h0,      "rd_cmp0"});
      vecs.push_back('{1'b0, 32'h100, 32'h0,        4'h0, 32'h0,      "rd_status"});
      vecs.push_back('{1'b1, 32'h008, 32'hAABBCCDD, 4'h1, 32'h0,      "wr_lane0"});
      vecs.push_back('{1'b0, 32'h008, 32'h0,        4'h0, 32'h00DD,   "lane0"});
      vecs.push_back('{1'b1, 32'h008, 32'hAABBCCDD, 4'h2, 32'h0,      "wr_lane1"});
      vecs.push_back('{1'b0, 32'h008, 32'h0,        4'h0, 32'hCCDD,   "lane1"});
      vecs.push_back('{1'b1, 32'h008, 32'h12345678, 4'hC, 32'h0,      "wr_upper"});
      vecs.push_back('{1'b0, 32'h008, 32'h0,        4'h0, 32'hCCDD,   "upper_lanes"});
      vecs.push_back('{1'b1, 32'h018, 32'hFFFF1234, 4'hF, 32'h0,      "wr_cmp1"});
      vecs.push_back('{1'b0, 32'h018, 32'h0,        4'h0, 32'h1234,   "cmp1_trunc"});
      vecs.push_back('{1'b1, 32'h000, 32'hFFFFFFF0, 4'hF, 32'h0,      "wr_ctrl_hi"});
      vecs.push_back('{1'b0, 32'h000, 32'h0,        4'h0, 32'h0,      "ctrl_hibits"});
      vecs.push_back('{1'b1, 32'h000, 32'h0000000C, 4'h1, 32'h0,      "wr_ctrl_c"});
      vecs.push_back('{1'b0, 32'h000, 32'h0,        4'h0, 32'hC,      "ctrl_rw"});
      vecs.push_back('{1'b1, 32'h000, 32'h0,        4'h1, 32'h0,      "wr_ctrl_0"});
      vecs.push_back('{1'b1, 32'h03C, 32'hFFFFFFFF, 4'hF, 32'h0,      "wr_rsvd"});
      vecs.push_back('{1'b0, 32'h03C, 32'h0,        4'h0, 32'h0,      "rsvd_reg"});
      vecs.push_back('{1'b1, 32'h050, 32'h0000000F, 4'hF, 32'h0,      "wr_ch5_ctrl"});
      vecs.push_back('{1'b0, 32'h050, 32'h0,        4'h0, 32'h0,      "ch5_ctrl"});
      vecs.push_back('{1'b1, 32'h054, 32'h00001234, 4'hF, 32'h0,      "wr_ch5_count"});
      vecs.push_back('{1'b0, 32'h054, 32'h0,        4'h0, 32'h0,      "ch5_count"});
      vecs.push_back('{1'b0, 32'h104, 32'h0,        4'h0, 32'h0,      "rsvd_status_off"});
      vecs.push_back('{1'b0, 32'h000, 32'h0,        4'h0, 32'h0,      "ch0_untouched"});
      vecs.push_back('{1'b0, 32'h010, 32'h0,        4'h0, 32'h0,      "ch1_ctrl_untouched"});
      vecs.push_back('{1'b0, 32'h014, 32'h0,        4'h0, 32'h0,      "ch1_count_untouched"});
      vecs.push_back('{1'b1, 32'h034, 32'h0000BEEF, 4'h3, 32'h0,      "wr_count3"});
      vecs.push_back('{1'b0, 32'h034, 32'h0,        4'h0, 32'hBEEF,   "count3"});

      for (int i = 0; i < vecs.size(); i++) begin
         wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd);
         if (!vecs[i].we) check(vecs[i].name, rd, vecs[i].exp);
      end
      check("count_o_ch3", ch_cnt(3), 32'hBEEF);
      check("count_o_ch1", ch_cnt(1), 32'h0);

      // Periodic up count on channel 1 with interrupt enabled.
      wb_write(32'h018, 32'd3, 4'hF);
      wb_write(32'h010, 32'h9, 4'h1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("periodic_count", ch_cnt(1), 32'((i + 1) % 4));
         if (i == 3) check("irq_not_yet", 32'(irq_o), 32'd0);
         if (i == 4) check("irq_periodic", 32'(irq_o), 32'd1);
      end
      wb_write(32'h010, 32'h8, 4'h1);
      wb_read_check("status_ch1", 32'h100, 32'h2);
      check("irq_held", 32'(irq_o), 32'd1);
      wb_write(32'h100, 32'h2, 4'h1);
      check("irq_clear", 32'(irq_o), 32'd0);
      wb_read_check("status_cleared", 32'h100, 32'h0);

      // One-shot down count on channel 2, interrupt disabled.
      wb_write(32'h024, 32'd5, 4'hF);
      wb_write(32'h020, 32'h7, 4'h1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("oneshot_count", ch_cnt(2), (i < 4) ? 32'(4 - i) : 32'd0);
         check("oneshot_irq", 32'(irq_o), 32'd0);
      end
      wb_read_check("oneshot_ctrl", 32'h020, 32'h6);
      wb_read_check("oneshot_status", 32'h100, 32'h4);
      wb_write(32'h100, 32'h4, 4'h1);

      // COMPARE=0 up mode: match every cycle; W1C collides with a set.
      wb_write(32'h008, 32'd0, 4'hF);
      wb_write(32'h000, 32'h9, 4'h1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("cmp0_hold", ch_cnt(0), 32'd0);
      end
      check("irq_cmp0", 32'(irq_o), 32'd1);
      wb_write(32'h100, 32'h1, 4'h1);
      check("w1c_collision_irq", 32'(irq_o), 32'd1);
      wb_read_check("w1c_collision", 32'h100, 32'h1);
      wb_write(32'h000, 32'h0, 4'h1);
      wb_write(32'h100, 32'h1, 4'h1);
      wb_read_check("w1c_clear", 32'h100, 32'h0);

      // Bus write to COUNT while channel 3 is counting.
      wb_write(32'h038, 32'hFFFF, 4'hF);
      wb_write(32'h030, 32'h1, 4'h1);
      wb_write(32'h034, 32'h10, 4'hF);
      check("cnt_wr_live", ch_cnt(3), 32'h11);
      wb_read_check("cnt_wr_read", 32'h034, 32'h11);
      wb_write(32'h030, 32'h0, 4'h1);

      // Back-to-back: cyc/stb held, ack toggles every cycle.
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_adr_i = 32'h018;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check("b2b_ack", 32'(bus.wbs_ack_o), (i % 2 == 0) ? 32'd1 : 32'd0);
         check("b2b_dat", bus.wbs_dat_o, (i % 2 == 0) ? 32'd3 : 32'd0);
      end
      @(negedge clk);
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;

      // Reset pulsed while an ack is high.
      wb_write(32'h000, 32'h9, 4'h1);
      repeat (2) @(negedge clk);
      check("irq_pre_rst", 32'(irq_o), 32'd1);
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = 1'b1;
      bus.wbs_adr_i = 32'h004;
      bus.wbs_dat_i = 32'h77;
      bus.wbs_sel_i = 4'hF;
      @(posedge clk);
      #1;
      check("rst_ack_before", 32'(bus.wbs_ack_o), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_ack_async", 32'(bus.wbs_ack_o), 32'd0);
      check("rst_irq_async", 32'(irq_o), 32'd0);
      check("rst_count_async", count_o[31:0], 32'd0);
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      wb_read_check("post_rst_ctrl0", 32'h000, 32'h0);
      wb_read_check("post_rst_count0", 32'h004, 32'h0);
      wb_read_check("post_rst_cmp0", 32'h008, 32'h0);
      wb_read_check("post_rst_cmp1", 32'h018, 32'h0);
      wb_read_check("post_rst_status", 32'h100, 32'h0);
      check("post_rst_count_lo", count_o[31:0], 32'd0);
      check("post_rst_count_hi", count_o[63:32], 32'd0);
      check("post_rst_irq", 32'(irq_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/wb_counter_bank.md
WB_COUNTER_BANK -- requirements
Module: wb_counter_bank

Interface
REQ-001 Parameter NCH, default 4, number of independent counter channels (legal range 1..8).
REQ-002 Parameter WIDTH, default 16, counter width in bits (legal range 1..32).
REQ-003 wb_clk_i  input  1  single clock for all logic.
REQ-004 wb_rst_ni  input  1  asynchronous active-low reset.
REQ-005 wbs_stb_i  input  1  Wishbone strobe.
REQ-006 wbs_cyc_i  input  1  Wishbone cycle.
REQ-007 wbs_we_i  input  1  write enable (1 = write).
REQ-008 wbs_sel_i  input  4  byte-lane enables for writes.
REQ-009 wbs_dat_i  input  32  write data.
REQ-010 wbs_adr_i  input  32  byte address; only bits [8:2] are decoded.
REQ-011 wbs_ack_o  output  1  transfer acknowledge.
REQ-012 wbs_dat_o  output  32  read data.
REQ-013 count_o  output  NCH*WIDTH  live counter values; channel n occupies bits [n*WIDTH +: WIDTH].
REQ-014 irq_o  output  1  level interrupt, OR of enabled match flags.

Function
REQ-015 Address map: adr[8]=0 selects channel adr[6:4] with register adr[3:2]: 0 CTRL, 1 COUNT, 2 COMPARE, 3 reserved; adr[8]=1, adr[3:2]=0 selects STATUS; all other offsets are reserved.
REQ-016 CTRL bits: [0] EN, [1] ONESHOT, [2] DOWN, [3] IEN; bits [31:4] read 0.
REQ-017 COUNT and COMPARE are WIDTH bits, zero-extended on read; bits above WIDTH are ignored on write.
REQ-018 STATUS bit n = match flag of channel n; bits >= NCH read 0; writing 1 clears a flag (W1C), writing 0 has no effect.
REQ-019 Writes honour wbs_sel_i per byte lane; bytes with sel=0 are left unchanged.
REQ-020 A request is cyc&stb&~wbs_ack_o; wbs_ack_o goes high exactly one cycle after the request and stays high for exactly one cycle.
REQ-021 Back-to-back requests: with cyc&stb held high, wbs_ack_o toggles, giving one transfer every 2 cycles.
REQ-022 The write takes effect at the clock edge where wbs_ack_o rises; read data is registered at that same edge and is valid while wbs_ack_o=1; wbs_dat_o=0 whenever wbs_ack_o=0.
REQ-023 Reserved offsets and channels >= NCH: writes are ignored, reads return 0, and the access is still acknowledged.
REQ-024 Up mode (DOWN=0), EN=1, COUNT!=COMPARE: COUNT increments by 1 per cycle.
REQ-025 Up mode, EN=1, COUNT==COMPARE: the channel flag is set; with ONESHOT=0 COUNT loads 0; with ONESHOT=1 COUNT holds and EN clears.
REQ-026 Down mode, EN=1, COUNT!=0: COUNT decrements by 1 per cycle.
REQ-027 Down mode, EN=1, COUNT==0: the flag is set; with ONESHOT=0 COUNT loads COMPARE; with ONESHOT=1 COUNT holds and EN clears.
REQ-028 EN=0: COUNT holds and no flag is set.
REQ-029 A bus write to COUNT or CTRL.EN in the same cycle as a count update or a one-shot EN clear: the bus write wins.
REQ-030 A W1C clear in the same cycle as a new match on that channel: the set wins and the flag stays 1.
REQ-031 irq_o = |(STATUS & IEN vector), registered, so it is valid one cycle after a flag or IEN change.
REQ-032 COMPARE=0 in up mode with ONESHOT=0: the flag is set every enabled cycle and COUNT stays 0.

Reset
REQ-033 wb_rst_ni=0 asynchronously clears all CTRL, COUNT, COMPARE and STATUS bits, wbs_ack_o, wbs_dat_o, irq_o and count_o to 0.
REQ-034 Reset asserted during a pending transfer drops wbs_ack_o immediately; the write is lost.
REQ-035 After reset deassertion, the first request is accepted on the first rising clock edge.

Verification
REQ-036 Read-after-reset: read CTRL, COUNT, COMPARE of channel 0 and STATUS -> all 0; each ack is exactly 1 cycle wide, 1 cycle after the request.
REQ-037 Periodic up: ch1 COMPARE=3, CTRL=0x9 -> COUNT sequence 0,1,2,3,0,...; STATUS[1]=1 and irq_o=1 one cycle after COUNT=3; W1C 0x2 -> irq_o=0.
REQ-038 One-shot down: ch2 COUNT=5, CTRL=0x7 -> counts 5..0, then holds at 0, CTRL reads 0x6, STATUS[2]=1, irq_o stays 0 (IEN=0).
REQ-039 Byte lanes: write 0xAABBCCDD to ch0 COMPARE with sel=0b0001 -> reads 0x00DD; then sel=0b0010 -> reads 0xCCDD.
REQ-040 Collisions: W1C on STATUS in the same cycle as a ch0 match -> flag stays 1; a COUNT write of 0x10 while counting -> the next read returns 0x10 plus elapsed cycles.
REQ-041 Out of range: with NCH=4, a write and read at channel 5 -> acked, reads 0, no channel modified; wb_rst_ni pulsed mid-transfer -> ack drops asynchronously and all registers read 0.
